// File: rtl/num_to_char.sv
// Binary-to-decimal ASCII converter: double-dabble one bit per clock, then one
// digit per clock MSD first with leading zeros skipped. Optional CR/LF: NUM2CHAR_CRLF_EN.
module num_to_char #(
   parameter int WIDTH = 32,
   parameter int NDIG  = 10
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start_update,
   input  logic [WIDTH-1:0] error_rate,
   output logic [7:0]       char,
   output logic             valid_o
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, EMIT, TERM} state_e;

   state_e              state_q, state_d;
   logic                start_q, start_d;
   logic [4*NDIG-1:0]   bcd_q, bcd_d;
   logic [WIDTH-1:0]    shift_q, shift_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic                seen_q, seen_d;
   logic [7:0]          char_q, char_d;
   logic                valid_q, valid_d;
`ifdef NUM2CHAR_CRLF_EN
   logic                term_q, term_d;
`endif

   logic [4*NDIG-1:0]   adj;
   logic [3:0]          digit;

   // Add-3 correction applied to every nibble before each shift.
   always_comb begin
      adj = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         else
            adj[4*i +: 4] = bcd_q[4*i +: 4];
      end
   end

   assign digit = bcd_q[int'(idx_q)*4 +: 4];

   always_comb begin
      state_d = state_q;
      start_d = start_update;
      bcd_d   = bcd_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      seen_d  = seen_q;
      char_d  = 8'h00;
      valid_d = 1'b0;
`ifdef NUM2CHAR_CRLF_EN
      term_d  = term_q;
`endif
      case (state_q)
         IDLE: begin
            if (start_update && !start_q) begin
               shift_d = error_rate;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            {bcd_d, shift_d} = {adj, shift_q} << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               idx_d   = IW'(NDIG - 1);
               seen_d  = 1'b0;
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (digit != 4'd0 || seen_q || idx_q == '0) begin
               char_d  = 8'h30 + {4'h0, digit};
               valid_d = 1'b1;
               seen_d  = 1'b1;
            end
            if (idx_q == '0) begin
`ifdef NUM2CHAR_CRLF_EN
               term_d  = 1'b0;
               state_d = TERM;
`else
               state_d = IDLE;
`endif
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end
`ifdef NUM2CHAR_CRLF_EN
         TERM: begin
            valid_d = 1'b1;
            if (!term_q) begin
               char_d = 8'h0D;
               term_d = 1'b1;
            end else begin
               char_d  = 8'h0A;
               term_d  = 1'b0;
               state_d = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         bcd_q   <= '0;
         shift_q <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         seen_q  <= 1'b0;
         char_q  <= 8'h00;
         valid_q <= 1'b0;
`ifdef NUM2CHAR_CRLF_EN
         term_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         bcd_q   <= bcd_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         seen_q  <= seen_d;
         char_q  <= char_d;
         valid_q <= valid_d;
`ifdef NUM2CHAR_CRLF_EN
         term_q  <= term_d;
`endif
      end
   end

   assign char    = char_q;
   assign valid_o = valid_q;

endmodule

// File: tb/tb_num_to_char.sv
// Testbench for num_to_char: directed and random conversions checked against a
// decimal-string reference model with per-character arrival cycles.
module tb_num_to_char;

   localparam int WIDTH = 32;
   localparam int NDIG  = 10;
   localparam int WIN   = WIDTH + NDIG + 10;

   logic             CLK = 1'b0;
   logic             RST = 1'b0;
   logic             start_update = 1'b0;
   logic [WIDTH-1:0] error_rate = '0;
   logic [7:0]       char;
   logic             valid_o;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0] exp_q[$];
   int         exp_c[$];
   logic [7:0] obs_q[$];
   int         obs_c[$];
   int         bad_idle;

   num_to_char #(.WIDTH(WIDTH), .NDIG(NDIG)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .start_update (start_update),
      .error_rate   (error_rate),
      .char         (char),
      .valid_o      (valid_o)
   );

   // clock
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: decimal string of v, MSD first, then optional CR LF. A string of
   // L digits lands on the last L of the NDIG emit cycles; cycle 1 is the first
   // negedge after the trigger edge.
   task automatic build_exp(input logic [31:0] v);
      logic [31:0] t;
      int          ndig_str;
      exp_q.delete();
      exp_c.delete();
      t = v;
      if (t == 0) exp_q.push_back(8'h30);
      while (t != 0) begin
         exp_q.push_front(8'(32'h30 + t % 10));
         t = t / 10;
      end
      ndig_str = exp_q.size();
`ifdef NUM2CHAR_CRLF_EN
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
`endif
      for (int j = 0; j < exp_q.size(); j++)
         exp_c.push_back(WIDTH + 2 + NDIG - ndig_str + j);
   endtask

   task automatic start_conv(input logic [31:0] v);
      @(negedge CLK);
      error_rate   = v;
      start_update = 1'b1;
   endtask

   task automatic collect(input int ncyc, input bit hold, input int inject_at);
      obs_q.delete();
      obs_c.delete();
      bad_idle = 0;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge CLK);
         if (valid_o === 1'b1) begin
            obs_q.push_back(char);
            obs_c.push_back(c);
         end else if (char !== 8'h00) begin
            bad_idle++;
         end
         if (c == 1) error_rate = $urandom;
         if (c == 1 && !hold) start_update = 1'b0;
         if (inject_at != 0 && c == inject_at) start_update = 1'b1;
         if (inject_at != 0 && c == inject_at + 1) start_update = 1'b0;
      end
   endtask

   task automatic check_conv(input logic [31:0] v, input string tag);
      int n;
      build_exp(v);
      chk({tag, "_count"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int j = 0; j < n; j++) begin
         chk($sformatf("%s_char%0d", tag, j), obs_q[j], exp_q[j]);
         chk($sformatf("%s_cyc%0d", tag, j), obs_c[j], exp_c[j]);
      end
      chk({tag, "_idle_char"}, bad_idle, 0);
   endtask

   initial begin
      logic [31:0] v;

      // reset held with start already high
      error_rate   = 32'd2136;
      start_update = 1'b1;
      repeat (3) @(negedge CLK);
      chk("reset_valid", valid_o, 1'b0);
      chk("reset_char", char, 8'h00);
      RST = 1'b1;
      collect(WIN, 1'b1, 0);
      check_conv(32'd2136, "rst_hold");
      collect(20, 1'b1, 0);
      chk("hold_quiet", obs_q.size(), 0);
      start_update = 1'b0;

      start_conv(32'd0);
      collect(WIN, 1'b0, 0);
      check_conv(32'd0, "zero");

      start_conv(32'hFFFF_FFFF);
      collect(WIN, 1'b0, 0);
      check_conv(32'hFFFF_FFFF, "max");
      if (obs_c.size() > 0) chk("max_first", obs_c[0], WIDTH + 2);

      // second rising edge while shifting must be ignored
      start_conv(32'd2136);
      collect(WIN, 1'b0, 10);
      check_conv(32'd2136, "mid_edge");
      start_conv(32'd7);
      collect(WIN, 1'b0, 0);
      check_conv(32'd7, "seven");

      // reset in the middle of emitting 2136
      start_conv(32'd2136);
      for (int c = 1; c <= WIDTH + 2 + NDIG - 4; c++) begin
         @(negedge CLK);
         if (c == 1) start_update = 1'b0;
      end
      chk("abort_first_valid", valid_o, 1'b1);
      chk("abort_first_char", char, 8'h32);
      RST = 1'b0;
      @(negedge CLK);
      chk("abort_valid", valid_o, 1'b0);
      chk("abort_char", char, 8'h00);
      RST = 1'b1;
      collect(20, 1'b0, 0);
      chk("abort_quiet", obs_q.size(), 0);

      start_conv(32'd105);
      collect(WIN, 1'b0, 0);
      check_conv(32'd105, "v105");

      for (int i = 0; i < 10; i++) begin
         v = $urandom >> $urandom_range(0, 31);
         start_conv(v);
         collect(WIN, 1'b0, 0);
         check_conv(v, $sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
